// File: rtl/dmac_ahb_pkg.sv
// Shared AHB-Lite encodings for the DMAC channel logic and the bring-up memory slave.
// Contents: HTrans / HResp / HSize encodings, slave FSM state enum, and the
// byte-lane strobe helper used by the memory slave.
package dmac_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_BUSY    = 2'b01;
    localparam logic [1:0] HTRANS_NON_SEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ     = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Little-endian lane select for a 32-bit bus; illegal sizes select no lanes.
    function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            SZ_BYTE: strb = 4'b0001 << lo;
            SZ_HALF: strb = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-addressed SRAM bank: DEPTH x DATA_W, byte-enable synchronous write,
// asynchronous read. Contents are not reset.
// Ports:
//   clk    in   clock, write on posedge
//   we     in   per-byte write enables
//   addr   in   word index shared by the read and write ports
//   wdata  in   write data
//   rdata  out  combinational read of mem[addr]
module ahb_sram_bank #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic [NB-1:0]     we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder backed by a local SRAM bank.
// Decodes address phases, applies byte/half/word writes through lane strobes,
// returns combinational read data, and produces the two-cycle ERROR response
// for out-of-range, oversize or misaligned accesses.
// Optional build macro AHB_WAIT_STATES_EN: inserts WAIT_CYCLES wait states in
// front of every legal data phase. Without it ST_WAIT is unreachable and no
// wait counter exists.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   HSel, HAddr, HTrans, HWrite, HSize, HReadyIn   address phase inputs
//   HWData              write data (data phase)
//   HReadyOut, HResp, HRData                       data phase response
//
// state     | meaning
// ST_IDLE   | no data phase in progress, zero-wait OKAY
// ST_ACCESS | completing data phase: read data driven / write committed
// ST_WAIT   | inserted wait state, HReadyOut low
// ST_ERR1   | first ERROR cycle, HReadyOut low
// ST_ERR2   | second ERROR cycle, HReadyOut high, next address accepted
module ahb_slave_mem
    import dmac_ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSel,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [1:0]        HTrans,
    input  logic              HWrite,
    input  logic [2:0]        HSize,
    input  logic [DATA_W-1:0] HWData,
    input  logic              HReadyIn,
    output logic              HReadyOut,
    output logic [1:0]        HResp,
    output logic [DATA_W-1:0] HRData
);

    localparam int AW = $clog2(DEPTH);

    slave_state_e  state_q, state_d;
    logic [AW+1:0] addr_q, addr_d;     // byte offset from BASE_ADDR
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
`ifdef AHB_WAIT_STATES_EN
    logic [7:0]    wait_cnt_q, wait_cnt_d;
`endif

    logic [ADDR_W-1:0] off_full;
    logic              addr_sample;
    logic              addr_legal;
    logic              aligned;
    logic              open_slot;
    logic              ready_out;
    logic [1:0]        resp;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Address decode and legality of the transfer currently on the bus.
    always_comb begin
        off_full    = HAddr - BASE_ADDR;
        addr_sample = HSel && HReadyIn &&
                      ((HTrans == HTRANS_NON_SEQ) || (HTrans == HTRANS_SEQ));
        case (HSize)
            SZ_HALF: aligned = (HAddr[0] == 1'b0);
            SZ_WORD: aligned = (HAddr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        addr_legal = (HAddr >= BASE_ADDR) &&
                     ((off_full >> 2) < ADDR_W'(DEPTH)) &&
                     (HSize <= SZ_WORD) && aligned;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
`ifdef AHB_WAIT_STATES_EN
        wait_cnt_d = wait_cnt_q;
`endif
        ready_out = 1'b1;
        resp      = HRESP_OKAY;
        mem_we    = 4'b0000;
        open_slot = 1'b0;

        case (state_q)
            ST_IDLE: begin
                open_slot = 1'b1;
            end
            ST_ACCESS: begin
                open_slot = 1'b1;
                if (write_q) begin
                    mem_we = lane_strobe(size_q, addr_q[1:0]);
                end
            end
            ST_WAIT: begin
                ready_out = 1'b0;
`ifdef AHB_WAIT_STATES_EN
                if (wait_cnt_q <= 8'd1) begin
                    state_d = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ERR1: begin
                ready_out = 1'b0;
                resp      = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                resp      = HRESP_ERROR;
                open_slot = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // States whose cycle ends a data phase may accept the next address phase.
        if (open_slot) begin
            state_d = ST_IDLE;
            if (addr_sample) begin
                addr_d  = off_full[AW+1:0];
                write_d = HWrite;
                size_d  = HSize;
                if (!addr_legal) begin
                    state_d = ST_ERR1;
                end
`ifdef AHB_WAIT_STATES_EN
                else if (WAIT_CYCLES > 0) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'(WAIT_CYCLES);
                end
`endif
                else begin
                    state_d = ST_ACCESS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
`ifdef AHB_WAIT_STATES_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
`ifdef AHB_WAIT_STATES_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // A write whose completing edge coincides with reset is dropped.
    ahb_sram_bank #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk   (clk),
        .we    (mem_we & {4{rst}}),
        .addr  (addr_q[AW+1:2]),
        .wdata (HWData),
        .rdata (mem_rdata)
    );

    assign HReadyOut = ready_out;
    assign HResp     = resp;
    assign HRData    = ((state_q == ST_ACCESS) && !write_q) ? mem_rdata : '0;

endmodule
